// File: rtl/bpsk_demod_if.sv
// Sample-side and decision-side signals of the BPSK integrate-and-dump demodulator.
interface bpsk_demod_if #(
  parameter int unsigned CNT_W = 4
);
  logic                     demod_ena;
  logic                     sample_valid;
  logic signed [15:0]       rx_sample;
  logic signed [15:0]       ref_sine;
  logic                     demod_active;
  logic                     data_out;
  logic                     data_valid;
  logic                     bit_weak;
  logic        [CNT_W-1:0]  sample_cnt;

  modport master (
    output demod_ena, sample_valid, rx_sample, ref_sine,
    input  demod_active, data_out, data_valid, bit_weak, sample_cnt
  );

  modport slave (
    input  demod_ena, sample_valid, rx_sample, ref_sine,
    output demod_active, data_out, data_valid, bit_weak, sample_cnt
  );
endinterface

// File: rtl/bpsk_demod.sv
// BPSK demodulator: multiply by aligned reference sine, integrate over one bit,
// then decide the bit from the sign of the integral and flag low-magnitude decisions.
module bpsk_demod #(
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned WEAK_THRESH     = 1048576
) (
  input  logic         clk,
  input  logic         rst,
  bpsk_demod_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(SAMPLES_PER_BIT);
  localparam int unsigned ACC_W = 32 + CNT_W + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic signed [31:0]      prod;
  logic                    prod_v;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;

  logic signed [31:0]      prod_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W:0]   sum_ext_c;
  logic        [ACC_W:0]   abs_c;
  logic                    last_c;

  // Full-precision product; both operands sign-extended so -32768*-32768 cannot wrap.
  assign prod_c    = 32'(bus.rx_sample) * 32'(bus.ref_sine);
  assign sum_c     = acc + ACC_W'(prod);
  // Magnitude one bit wider than the accumulator so negating the most negative sum is safe.
  assign sum_ext_c = (ACC_W+1)'(sum_c);
  assign abs_c     = sum_ext_c[ACC_W] ? $unsigned(-sum_ext_c) : $unsigned(sum_ext_c);
  assign last_c    = (cnt == CNT_W'(SAMPLES_PER_BIT - 1));

  assign bus.sample_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.demod_active <= 1'b0;
      bus.data_out     <= 1'b0;
      bus.data_valid   <= 1'b0;
      bus.bit_weak     <= 1'b0;
      prod             <= '0;
      prod_v           <= 1'b0;
      acc              <= '0;
      cnt              <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: begin
          prod_v <= 1'b0;
          acc    <= '0;
          cnt    <= '0;
          if (bus.demod_ena) begin
            state            <= RUN;
            bus.demod_active <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.demod_ena) begin
            // Disable discards the partial bit and any in-flight product, even on a dump edge.
            state            <= IDLE;
            bus.demod_active <= 1'b0;
            prod_v           <= 1'b0;
            acc              <= '0;
            cnt              <= '0;
          end else begin
            prod_v <= bus.sample_valid;
            if (bus.sample_valid) prod <= prod_c;
            if (prod_v) begin
              if (last_c) begin
                bus.data_out   <= ~sum_c[ACC_W-1];
                bus.bit_weak   <= (abs_c < (ACC_W+1)'(WEAK_THRESH));
                bus.data_valid <= 1'b1;
                acc            <= '0;
                cnt            <= '0;
              end else begin
                acc <= sum_c;
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
Receive-side counterpart of the BPSK mixer. It multiplies each received 16-bit sample by a locally generated reference sine that is phase-aligned with the sample. It integrates the products over one bit period (integrate-and-dump), then decides the bit from the sign of the integral. It sits after the ADC/sample front end and before the bit framing/controller logic, emitting one decided bit per SAMPLES_PER_BIT accepted samples.

Parameters:
SAMPLES_PER_BIT, 16, number of accepted samples integrated per bit; must be ≥2.
WEAK_THRESH, 1048576, magnitude below which a decided bit is flagged weak; unsigned, compared against |acc|.
ACC_W, 32+$clog2(SAMPLES_PER_BIT)+1, accumulator width; localparam, not overridable.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
demod_ena  input  1  enables demodulation; low flushes and idles the block.
sample_valid  input  1  strobe: rx_sample and ref_sine valid this cycle.
rx_sample  input  16  signed received sample.
ref_sine  input  16  signed reference sine, sample-aligned with rx_sample.
demod_active  output  1  registered copy of the run state (1 in RUN).
data_out  output  1  decided bit; holds until the next decision.
data_valid  output  1  one-cycle pulse when data_out is updated.
bit_weak  output  1  qualifies data_out: |integral| < WEAK_THRESH; updated with data_out.
sample_cnt  output  $clog2(SAMPLES_PER_BIT)  samples accumulated in the current bit.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; demod_active, data_out, data_valid, bit_weak, sample_cnt, accumulator, and product pipeline register/valid are all 0. rst has priority over every other input.
- States: IDLE, RUN.
  - IDLE→RUN on an edge with demod_ena=1.
  - RUN→IDLE on an edge with demod_ena=0.
  - In IDLE, the accumulator, sample_cnt and pipeline are held at 0, and no samples are accepted.
- Stage 1 (product): in RUN, when sample_valid=1 and demod_ena=1, register prod = rx_sample*ref_sine (32-bit signed, full precision) and set prod_v=1. Otherwise prod_v=0.
- Stage 2 (integrate): when prod_v=1:
  - If sample_cnt < SAMPLES_PER_BIT-1: acc <= acc + sign-extended prod; sample_cnt++.
  - If sample_cnt = SAMPLES_PER_BIT-1 (dump): let sum = acc + prod. Then data_out <= (sum ≥ 0); bit_weak <= (|sum| < WEAK_THRESH); data_valid <= 1; acc <= 0; sample_cnt <= 0.
- data_valid is 0 on every other cycle; it is never high two consecutive cycles.
- Latency: the final sample of a bit is accepted at edge N. data_out, bit_weak and data_valid change at edge N+1, so data_valid is high for the cycle after N+1.
- Sign convention matches the transmitter: data=1 is sent as +sine, giving a positive correlation, so data_out=1. A tie (sum = 0) decides 1 and is always weak.
- Arithmetic: signed throughout. -32768*-32768 = +2^30 must be represented without wrap. ACC_W guarantees no overflow for SAMPLES_PER_BIT full-scale products of either sign. |sum| is computed at ACC_W+1 bits.
- sample_valid gaps: there is no timeout. Integration simply waits, and bits are counted in accepted samples only.
- demod_ena falling mid-bit:
  - The partial integral and any in-flight prod are discarded.
  - No data_valid is produced; data_out and bit_weak keep their last values.
  - The next enable starts a fresh bit at sample_cnt=0.
- demod_ena falling on the same edge that would dump: the dump is suppressed (disable wins).
- rst mid-bit: same discard as disable, plus the output clear listed under Reset.
- sample_valid while demod_ena=0 is ignored.

Test Plan:
1. Reset: rst=1 for 3 cycles with random inputs → all outputs 0, no data_valid; release with demod_ena=0 → outputs stay 0.
2. Positive bit: demod_ena=1, 16 samples rx=ref=1000 → single data_valid at edge N+1 after the 16th sample; data_out=1, bit_weak=0 (sum=16,000,000); sample_cnt returns to 0.
3. Negative bit with gaps: rx=-1000, ref=1000, sample_valid high every 3rd cycle → data_out=0, bit_weak=0, exactly one data_valid after the 16th accepted sample.
4. Full-scale and tie:
   - 16 samples rx=ref=-32768 → data_out=1, sum=2^34, no overflow.
   - Then 8 samples (+1000,+1000) and 8 samples (-1000,+1000) → sum=0, data_out=1, bit_weak=1.
5. Back-to-back bits: 64 continuous samples with rx sign pattern +,-,+,+ per 16-sample bit (ref=1000) → data_out sequence 1,0,1,1, each with one data_valid pulse spaced 16 cycles apart.
6. Abort:
   - Drop demod_ena after 10 samples → no data_valid, data_out unchanged, demod_active=0.
   - Re-enable and send 16 samples (rx=-500, ref=500) → data_out=0.
   - Repeat the abort with rst=1 at sample 10 → all outputs 0.
